// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state type and field helpers for the
// iterative FPU blocks (square, sqrt, div).
package fp_pkg;

  localparam int BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7fc0_0000;
  localparam logic [31:0] PINF = 32'h7f80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StClass,
    StMul,
    StNorm,
    StDone
  } fp_state_e;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] fp_mant(input logic [31:0] f);
    return f[22:0];
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even and pack a 48-bit mantissa product into a
// single-precision result; overflow saturates to +inf, underflow flushes to zero.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic [47:0]        prod,
  input  logic signed [9:0]  exp_in,
  output logic [31:0]        result
);

  logic [22:0]       mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       mant_rnd;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;

  always_comb begin
    if (prod[47]) begin
      mant     = prod[46:24];
      guard    = prod[23];
      sticky   = |prod[22:0];
      exp_norm = exp_in + 10'sd1;
    end else begin
      mant     = prod[45:23];
      guard    = prod[22];
      sticky   = |prod[21:0];
      exp_norm = exp_in;
    end

    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {23'd0, round_up};
    // A carry out of the rounded mantissa leaves its fraction bits at zero.
    exp_fin  = mant_rnd[23] ? exp_norm + 10'sd1 : exp_norm;

    if (exp_fin >= 10'sd255) begin
      result = PINF;
    end else if (exp_fin <= 10'sd0) begin
      result = ZERO;
    end else begin
      result = {1'b0, exp_fin[7:0], mant_rnd[22:0]};
    end
  end

endmodule

// File: rtl/fp_square.sv
// Multi-cycle single-precision squarer: classify, 24-step shift-add mantissa
// multiply, then round/pack. start/done handshake, result held until next done.
module fp_square
  import fp_pkg::*;
#(
  parameter int unsigned MUL_BITS = 24
) (
  input  logic        fp_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] A,
  output logic [31:0] Out,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LastStep = 5'(MUL_BITS - 1);

  fp_state_e state_q, state_d;
  logic [30:0] a_q, a_d;
  logic [47:0] acc_q, acc_d;
  logic [23:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic [31:0] out_q, out_d;

  logic [47:0]       mcand;
  logic signed [9:0] exp_raw;
  logic [31:0]       packed_res;

  // The sign is dropped at capture: a square is never negative.
  assign mcand   = {24'd0, 1'b1, a_q[22:0]};
  assign exp_raw = $signed({1'b0, a_q[30:23], 1'b0}) - 10'(BIAS);

  fp_round_pack u_round_pack (
    .prod   (acc_q),
    .exp_in (exp_raw),
    .result (packed_res)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    out_d      = out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A[30:0];
          state_d = StClass;
        end
      end
      StClass: begin
        if (fp_exp({1'b0, a_q}) == 8'h00) begin
          spec_d     = 1'b1;
          spec_val_d = ZERO;
          state_d    = StNorm;
        end else if (fp_exp({1'b0, a_q}) == 8'hff) begin
          spec_d     = 1'b1;
          spec_val_d = (fp_mant({1'b0, a_q}) != 23'd0) ? QNAN : PINF;
          state_d    = StNorm;
        end else begin
          spec_d   = 1'b0;
          acc_d    = 48'd0;
          mplier_d = {1'b1, fp_mant({1'b0, a_q})};
          cnt_d    = 5'd0;
          state_d  = StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + (mcand << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LastStep) begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        out_d   = spec_q ? spec_val_q : packed_res;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge fp_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      a_q        <= 31'd0;
      acc_q      <= 48'd0;
      mplier_q   <= 24'd0;
      cnt_q      <= 5'd0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      out_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      out_q      <= out_d;
    end
  end

  assign Out  = out_q;
  assign busy = (state_q == StClass) || (state_q == StMul) || (state_q == StNorm);
  assign done = (state_q == StDone);

endmodule
